// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/video arbiter in front of a single-outstanding SDRAM controller port
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_i,

    input  logic                  cpu_sel_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_wr_data_i,
    input  logic [3:0]            cpu_wr_mask_i,
    output logic                  cpu_ack_o,
    output logic [31:0]           cpu_rd_data_o,

    input  logic                  vid_sel_i,
    input  logic [ADDR_WIDTH-1:0] vid_addr_i,
    output logic                  vid_ack_o,
    output logic [31:0]           vid_rd_data_o,

    output logic                  mem_sel_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wr_data_o,
    output logic [3:0]            mem_wr_mask_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rd_data_i,

    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_CPU = 2'd1,
        ST_GRANT_VID = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t                state_q;
    logic [7:0]            starve_cnt_q;
    logic                  mem_sel_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wr_data_q;
    logic [3:0]            mem_wr_mask_q;

    // Video wins ties until the CPU has lost STARVE_LIMIT arbitrations in a row.
    logic cpu_wins;
    assign cpu_wins = cpu_sel_i && (!vid_sel_i || (starve_cnt_q == STARVE_MAX));

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            starve_cnt_q  <= 8'd0;
            mem_sel_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= 32'd0;
            mem_wr_mask_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_wins) begin
                        state_q       <= ST_GRANT_CPU;
                        starve_cnt_q  <= 8'd0;
                        mem_sel_q     <= 1'b1;
                        mem_we_q      <= cpu_we_i;
                        mem_addr_q    <= cpu_addr_i;
                        mem_wr_data_q <= cpu_wr_data_i;
                        mem_wr_mask_q <= cpu_wr_mask_i;
                    end else if (vid_sel_i) begin
                        state_q       <= ST_GRANT_VID;
                        mem_sel_q     <= 1'b1;
                        mem_we_q      <= 1'b0;
                        mem_addr_q    <= vid_addr_i;
                        mem_wr_data_q <= 32'd0;
                        mem_wr_mask_q <= 4'd0;
                        if (!cpu_sel_i) begin
                            starve_cnt_q <= 8'd0;
                        end else if (starve_cnt_q != STARVE_MAX) begin
                            starve_cnt_q <= starve_cnt_q + 8'd1;
                        end
                    end else begin
                        starve_cnt_q <= 8'd0;
                    end
                end
                ST_GRANT_CPU, ST_GRANT_VID: begin
                    // Fields stay frozen; only the controller's ack ends the grant.
                    if (mem_ack_i) begin
                        state_q   <= ST_IDLE;
                        mem_sel_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_sel_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack_o     = (state_q == ST_GRANT_CPU) && mem_ack_i;
    assign vid_ack_o     = (state_q == ST_GRANT_VID) && mem_ack_i;
    assign cpu_rd_data_o = cpu_ack_o ? mem_rd_data_i : 32'd0;
    assign vid_rd_data_o = vid_ack_o ? mem_rd_data_i : 32'd0;

    assign mem_sel_o     = mem_sel_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign mem_wr_mask_o = mem_wr_mask_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scenario tasks plus randomized traffic against a rule-level arbitration model
module tb_mem_arbiter;
    localparam int AW  = 24;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          cpu_sel_i, cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [31:0]   cpu_wr_data_i;
    logic [3:0]    cpu_wr_mask_i;
    logic          cpu_ack_o;
    logic [31:0]   cpu_rd_data_o;
    logic          vid_sel_i;
    logic [AW-1:0] vid_addr_i;
    logic          vid_ack_o;
    logic [31:0]   vid_rd_data_o;
    logic          mem_sel_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wr_data_o;
    logic [3:0]    mem_wr_mask_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rd_data_i;
    logic          busy_o;

    int errors = 0;
    int checks = 0;
    int starve_m = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_i(reset_i),
        .cpu_sel_i(cpu_sel_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wr_data_i(cpu_wr_data_i), .cpu_wr_mask_i(cpu_wr_mask_i),
        .cpu_ack_o(cpu_ack_o), .cpu_rd_data_o(cpu_rd_data_o),
        .vid_sel_i(vid_sel_i), .vid_addr_i(vid_addr_i),
        .vid_ack_o(vid_ack_o), .vid_rd_data_o(vid_rd_data_o),
        .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_mask_o(mem_wr_mask_o),
        .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Arbitration rule: 1 = CPU, 2 = video, 0 = nobody; tracks consecutive CPU losses.
    task automatic model_pick(input logic c, input logic v, output int w);
        if (c && v && starve_m < LIM) begin
            w = 2;
            starve_m = starve_m + 1;
        end else if (c) begin
            w = 1;
            starve_m = 0;
        end else if (v) begin
            w = 2;
            starve_m = 0;
        end else begin
            w = 0;
            starve_m = 0;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        cpu_sel_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wr_data_i = 0; cpu_wr_mask_i = 0;
        vid_sel_i = 0; vid_addr_i = '0; mem_ack_i = 0; mem_rd_data_i = 0;
        starve_m = 0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({cpu_ack_o, vid_ack_o, mem_sel_o, mem_we_o, busy_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {cpu_ack_o, vid_ack_o, mem_sel_o, mem_we_o, busy_o});
        end
        checks++;
        if ({mem_addr_o, mem_wr_data_o, mem_wr_mask_o} !== '0) begin
            errors++; $display("FAIL reset_fields: got %h/%h/%h want 0", mem_addr_o, mem_wr_data_o, mem_wr_mask_o);
        end
    endtask

    task automatic test_cpu_write();
        logic [31:0] rd;
        do_reset();
        cpu_sel_i = 1; cpu_we_i = 1; cpu_addr_i = 24'h000100; cpu_wr_data_i = 32'hDEADBEEF; cpu_wr_mask_i = 4'hF;
        @(negedge clk);
        checks++;
        if (mem_sel_o !== 1'b0) begin errors++; $display("FAIL cpu_wr_latency: mem_sel got %b want 0", mem_sel_o); end
        @(negedge clk);
        checks++;
        if ({mem_sel_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o} !== {1'b1, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF}) begin
            errors++; $display("FAIL cpu_wr_fields: got sel=%b we=%b a=%h d=%h m=%h", mem_sel_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o);
        end
        @(negedge clk);
        checks++;
        if ({mem_sel_o, busy_o, cpu_ack_o, vid_ack_o} !== 4'b1100) begin
            errors++; $display("FAIL cpu_wr_hold: got %b want 1100", {mem_sel_o, busy_o, cpu_ack_o, vid_ack_o});
        end
        @(negedge clk);
        rd = $urandom; mem_rd_data_i = rd; mem_ack_i = 1;
        #1;
        checks++;
        if ({cpu_ack_o, vid_ack_o, mem_sel_o} !== 3'b101 || cpu_rd_data_o !== rd) begin
            errors++; $display("FAIL cpu_wr_ack: got ack=%b%b sel=%b rd=%h want 101 rd=%h", cpu_ack_o, vid_ack_o, mem_sel_o, cpu_rd_data_o, rd);
        end
        @(posedge clk);
        #1 mem_ack_i = 0; cpu_sel_i = 0;
        @(negedge clk);
        checks++;
        if ({mem_sel_o, busy_o, cpu_ack_o, vid_ack_o} !== 4'b0000) begin
            errors++; $display("FAIL cpu_wr_done: got %b want 0000", {mem_sel_o, busy_o, cpu_ack_o, vid_ack_o});
        end
    endtask

    task automatic test_vid_read();
        do_reset();
        vid_sel_i = 1; vid_addr_i = 24'h00A000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_sel_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o} !== {1'b1, 1'b0, 24'h00A000, 32'd0, 4'd0}) begin
            errors++; $display("FAIL vid_fields: got sel=%b we=%b a=%h d=%h m=%h", mem_sel_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o);
        end
        mem_rd_data_i = 32'h12345678; mem_ack_i = 1;
        #1;
        checks++;
        if ({vid_ack_o, cpu_ack_o} !== 2'b10 || vid_rd_data_o !== 32'h12345678 || cpu_rd_data_o !== 32'd0) begin
            errors++; $display("FAIL vid_ack: got ack=%b%b vrd=%h crd=%h want 10 12345678 0", vid_ack_o, cpu_ack_o, vid_rd_data_o, cpu_rd_data_o);
        end
        @(posedge clk);
        #1 mem_ack_i = 0; vid_sel_i = 0;
        @(negedge clk);
        checks++;
        if ({mem_sel_o, busy_o, vid_rd_data_o} !== 34'd0) begin
            errors++; $display("FAIL vid_done: got sel=%b busy=%b rd=%h want 0", mem_sel_o, busy_o, vid_rd_data_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cpu_sel_i = 1; cpu_we_i = 0; cpu_addr_i = 24'h0ABCDE; cpu_wr_mask_i = 4'h3; cpu_wr_data_i = 32'h55;
        vid_sel_i = 1; vid_addr_i = 24'h012345;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_sel_o, mem_addr_o, mem_wr_mask_o} !== {1'b1, 24'h012345, 4'h0}) begin
            errors++; $display("FAIL simul_first: got sel=%b a=%h m=%h want 1 012345 0", mem_sel_o, mem_addr_o, mem_wr_mask_o);
        end
        mem_ack_i = 1;
        #1;
        checks++;
        if ({vid_ack_o, cpu_ack_o} !== 2'b10) begin errors++; $display("FAIL simul_vack: got %b%b want 10", vid_ack_o, cpu_ack_o); end
        @(posedge clk);
        #1 mem_ack_i = 0; vid_sel_i = 0;
        @(negedge clk);
        checks++;
        if (mem_sel_o !== 1'b0) begin errors++; $display("FAIL simul_gap: mem_sel got %b want 0", mem_sel_o); end
        @(negedge clk);
        checks++;
        if ({mem_sel_o, mem_addr_o, mem_wr_mask_o, mem_wr_data_o} !== {1'b1, 24'h0ABCDE, 4'h3, 32'h55}) begin
            errors++; $display("FAIL simul_second: got sel=%b a=%h m=%h d=%h", mem_sel_o, mem_addr_o, mem_wr_mask_o, mem_wr_data_o);
        end
        mem_ack_i = 1;
        #1;
        checks++;
        if ({vid_ack_o, cpu_ack_o} !== 2'b01) begin errors++; $display("FAIL simul_cack: got %b%b want 01", vid_ack_o, cpu_ack_o); end
        @(posedge clk);
        #1 mem_ack_i = 0; cpu_sel_i = 0;
    endtask

    task automatic test_starvation();
        logic [9:0] exp_cpu;
        logic       got_cpu;
        exp_cpu = 10'b10_0001_0000;
        do_reset();
        cpu_sel_i = 1; cpu_we_i = 1; cpu_addr_i = 24'h111111; cpu_wr_data_i = 32'hA5A5A5A5; cpu_wr_mask_i = 4'h9;
        vid_sel_i = 1; vid_addr_i = 24'h222222;
        @(negedge clk);
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            got_cpu = (mem_addr_o == 24'h111111);
            checks++;
            if (mem_sel_o !== 1'b1 || got_cpu !== exp_cpu[g]) begin
                errors++; $display("FAIL starve_order[%0d]: got sel=%b cpu=%b want sel=1 cpu=%b", g, mem_sel_o, got_cpu, exp_cpu[g]);
            end
            repeat (2) @(negedge clk);
            mem_ack_i = 1;
            #1;
            checks++;
            if ({cpu_ack_o, vid_ack_o} !== {exp_cpu[g], ~exp_cpu[g]}) begin
                errors++; $display("FAIL starve_ack[%0d]: got %b%b want %b%b", g, cpu_ack_o, vid_ack_o, exp_cpu[g], ~exp_cpu[g]);
            end
            @(posedge clk);
            #1 mem_ack_i = 0;
            @(negedge clk);
            checks++;
            if (mem_sel_o !== 1'b0) begin errors++; $display("FAIL starve_gap[%0d]: mem_sel got %b want 0", g, mem_sel_o); end
        end
        cpu_sel_i = 0; vid_sel_i = 0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cpu_sel_i = 1; cpu_we_i = 1; cpu_addr_i = 24'h0F0F0F; cpu_wr_data_i = 32'hCAFEF00D; cpu_wr_mask_i = 4'h5;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_sel_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: mem_sel got %b want 1", mem_sel_o); end
        #1 reset_i = 0;
        #1;
        checks++;
        if ({mem_sel_o, busy_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o} !== '0) begin
            errors++; $display("FAIL rst_mid_async: got sel=%b busy=%b we=%b a=%h", mem_sel_o, busy_o, mem_we_o, mem_addr_o);
        end
        cpu_sel_i = 0; starve_m = 0;
        @(posedge clk);
        #1 reset_i = 1;
        @(negedge clk);
        mem_ack_i = 1; mem_rd_data_i = 32'h77;
        #1;
        checks++;
        if ({cpu_ack_o, vid_ack_o, cpu_rd_data_o} !== 34'd0) begin
            errors++; $display("FAIL rst_mid_ack: got ack=%b%b rd=%h want 0", cpu_ack_o, vid_ack_o, cpu_rd_data_o);
        end
        #1 mem_ack_i = 0;
        @(negedge clk);
        checks++;
        if ({mem_sel_o, busy_o} !== 2'b00) begin errors++; $display("FAIL rst_mid_state: got %b want 00", {mem_sel_o, busy_o}); end
    endtask

    task automatic test_idle_ack();
        do_reset();
        @(negedge clk);
        mem_ack_i = 1; mem_rd_data_i = 32'hFFFF0000;
        #1;
        checks++;
        if ({cpu_ack_o, vid_ack_o, busy_o, mem_sel_o} !== 4'b0000 || {cpu_rd_data_o, vid_rd_data_o} !== 64'd0) begin
            errors++; $display("FAIL idle_ack: got %b rd=%h/%h want 0000", {cpu_ack_o, vid_ack_o, busy_o, mem_sel_o}, cpu_rd_data_o, vid_rd_data_o);
        end
        #1 mem_ack_i = 0;
        @(negedge clk);
        checks++;
        if ({busy_o, mem_sel_o} !== 2'b00) begin errors++; $display("FAIL idle_ack_after: got %b want 00", {busy_o, mem_sel_o}); end
    endtask

    task automatic test_random();
        logic          cp, vp, ec;
        int            w, d;
        logic [31:0]   rd;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wd;
        logic [3:0]    e_m;
        cp = 0; vp = 0;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            if (!cp && ($urandom % 2 == 0)) begin
                cp = 1; cpu_we_i = 1'($urandom); cpu_addr_i = AW'($urandom);
                cpu_wr_data_i = $urandom; cpu_wr_mask_i = 4'($urandom);
            end
            if (!vp && ($urandom % 2 == 0)) begin vp = 1; vid_addr_i = AW'($urandom); end
            if (!cp && !vp) begin vp = 1; vid_addr_i = AW'($urandom); end
            cpu_sel_i = cp; vid_sel_i = vp;
            model_pick(cp, vp, w);
            if (w == 1) begin
                e_we = cpu_we_i; e_addr = cpu_addr_i; e_wd = cpu_wr_data_i; e_m = cpu_wr_mask_i;
            end else begin
                e_we = 0; e_addr = vid_addr_i; e_wd = 0; e_m = 0;
            end
            ec = (w == 1);
            @(negedge clk);
            checks++;
            if ({mem_sel_o, busy_o} !== 2'b00) begin errors++; $display("FAIL rnd_gap[%0d]: got %b want 00", it, {mem_sel_o, busy_o}); end
            if ($urandom % 4 == 0) begin
                mem_ack_i = 1; mem_rd_data_i = $urandom;
                #1;
                checks++;
                if ({cpu_ack_o, vid_ack_o} !== 2'b00) begin errors++; $display("FAIL rnd_idle_ack[%0d]: got %b%b want 00", it, cpu_ack_o, vid_ack_o); end
                #1 mem_ack_i = 0;
            end
            @(negedge clk);
            d = $urandom_range(0, 3);
            for (int k = 0; k <= d; k++) begin
                checks++;
                if ({mem_sel_o, busy_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o} !== {2'b11, e_we, e_addr, e_wd, e_m}
                    || {cpu_ack_o, vid_ack_o} !== 2'b00) begin
                    errors++; $display("FAIL rnd_grant[%0d.%0d]: got sel=%b we=%b a=%h d=%h m=%h want 1 %b %h %h %h", it, k,
                                       mem_sel_o, mem_we_o, mem_addr_o, mem_wr_data_o, mem_wr_mask_o, e_we, e_addr, e_wd, e_m);
                end
                if ($urandom % 3 == 0) begin
                    if (ec) cpu_sel_i = 0; else vid_sel_i = 0;
                end
                if (k < d) @(negedge clk);
            end
            rd = $urandom; mem_rd_data_i = rd; mem_ack_i = 1;
            #1;
            checks++;
            if ({cpu_ack_o, vid_ack_o} !== {ec, ~ec} || cpu_rd_data_o !== (ec ? rd : 32'd0) || vid_rd_data_o !== (ec ? 32'd0 : rd)) begin
                errors++; $display("FAIL rnd_ack[%0d]: got ack=%b%b crd=%h vrd=%h want %b%b rd=%h", it,
                                   cpu_ack_o, vid_ack_o, cpu_rd_data_o, vid_rd_data_o, ec, ~ec, rd);
            end
            @(posedge clk);
            #1 mem_ack_i = 0;
            if (ec) cp = 0; else vp = 0;
            cpu_sel_i = cp; vid_sel_i = vp;
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_vid_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_grant();
        test_idle_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
